aes_output_fifo: RTL and testbench

// Result buffer directly downstream of aes_cipher_top. Captures each 128-bit

---
 rtl/aes_output_fifo.sv | 124 ++++++++++++
 tb/tb_aes_output_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_output_fifo.sv
// ---------------------------------------------------------------------------
// aes_output_fifo
// Result buffer that sits directly after aes_cipher_top. Every one-cycle
// done_i pulse captures a 128-bit ciphertext into a small first-word-fall-
// through FIFO. The host drains words over a valid/ready handshake. A block
// that arrives while the FIFO is full and not popping is dropped, and the
// drop is recorded in a sticky overflow flag.
//
// Ports
//   clk         in   1      single clock, all state on the rising edge
//   rst         in   1      asynchronous, active-low reset
//   done_i      in   1      cipher done pulse; text_in valid this cycle
//   text_in     in   128    ciphertext from the cipher core
//   ready_i     in   1      consumer accepts text_o this cycle
//   clr_ovf_i   in   1      synchronous clear of overflow_o
//   text_o      out  128    head-of-FIFO ciphertext, 0 while valid_o is low
//   valid_o     out  1      FIFO non-empty, text_o valid
//   done_o      out  1      one-cycle pulse after each completed pop
//   count_o     out  CW     occupancy, 0..DEPTH
//   full_o      out  1      count_o == DEPTH
//   overflow_o  out  1      sticky: a done_i was dropped
//
// Handshake: a word transfers on a rising edge where valid_o and ready_i are
// both high. valid_o never depends on ready_i, and once high text_o is held
// stable until that transfer. ready_i while valid_o is low does nothing.
//
// There is no explicit FSM: the EMPTY / PARTIAL / FULL condition is fully
// described by count_o, with valid_o and full_o registered alongside it so
// that all three are plain flops.
// ---------------------------------------------------------------------------
module aes_output_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done_i,
  input  logic [127:0]  text_in,
  input  logic          ready_i,
  input  logic          clr_ovf_i,
  output logic [127:0]  text_o,
  output logic          valid_o,
  output logic          done_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [127:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_full;
  logic          r_done;
  logic          r_ovf;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;

  // A full FIFO may still accept a word when the head leaves in the same
  // cycle, since the freed slot is the one being written behind it.
  assign w_pop  = r_valid & ready_i;
  assign w_push = done_i & (~r_full | w_pop);
  assign w_drop = done_i & r_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Storage is intentionally left out of reset; valid_o gates what is seen.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= text_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so they wrap naturally.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_done  <= w_pop;
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign text_o     = r_valid ? r_mem[r_rd_ptr] : 128'h0;
  assign valid_o    = r_valid;
  assign done_o     = r_done;
  assign count_o    = r_count;
  assign full_o     = r_full;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_aes_output_fifo.sv
// ---------------------------------------------------------------------------
// tb_aes_output_fifo
// Self-checking bench for aes_output_fifo. Inputs are applied 1 time unit
// after a rising edge by the drive task, which also keeps a reference model
// (occupancy, overflow flag, expected-word queue). A negedge monitor pops
// the expected queue whenever the DUT hands over a word and compares it,
// and also checks valid_o and done_o against the model every cycle.
// ---------------------------------------------------------------------------
module tb_aes_output_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          done_i;
  logic [127:0]  text_in;
  logic          ready_i;
  logic          clr_ovf_i;
  logic [127:0]  text_o;
  logic          valid_o;
  logic          done_o;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          overflow_o;

  int            errors   = 0;
  int            checks   = 0;
  int            n_popped = 0;

  logic [127:0]  exp_q[$];
  int            m_count    = 0;
  logic          m_ovf      = 1'b0;
  logic          m_last_pop = 1'b0;

  aes_output_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .done_i     (done_i),
    .text_in    (text_in),
    .ready_i    (ready_i),
    .clr_ovf_i  (clr_ovf_i),
    .text_o     (text_o),
    .valid_o    (valid_o),
    .done_o     (done_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .overflow_o (overflow_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  // Called at posedge+1; applies inputs for one cycle, returns at the next
  // posedge+1 with the model advanced past that edge.
  task automatic drive(input logic d, input logic [127:0] t,
                       input logic r, input logic c);
    logic pop;
    logic push;
    done_i    = d;
    text_in   = t;
    ready_i   = r;
    clr_ovf_i = c;
    pop  = (m_count != 0) && r;
    push = d && ((m_count < DEPTH) || pop);
    if (push) exp_q.push_back(t);
    @(posedge clk);
    #1;
    if (d && !push) m_ovf = 1'b1;
    else if (c)     m_ovf = 1'b0;
    m_count    = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
    m_last_pop = pop;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (m_count != 0 && n < budget) begin
      drive(1'b0, 128'h0, 1'b1, 1'b0);
      n++;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      if (done_o !== m_last_pop) begin
        errors++;
        $display("FAIL mon_done_o: got %b want %b at %0t", done_o, m_last_pop, $time);
      end
      checks++;
      if (valid_o !== (m_count != 0)) begin
        errors++;
        $display("FAIL mon_valid_o: got %b want %b at %0t", valid_o, (m_count != 0), $time);
      end
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        checks++;
        n_popped++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_pop_data: got %h want <no word expected> at %0t", text_o, $time);
        end else begin
          logic [127:0] exp_w;
          exp_w = exp_q.pop_front();
          if (text_o !== exp_w) begin
            errors++;
            $display("FAIL mon_pop_data: got %h want %h at %0t", text_o, exp_w, $time);
          end
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0; done_i = 1'b0; text_in = '0; ready_i = 1'b0; clr_ovf_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow_o); end
    checks++; if (text_o !== 128'h0) begin errors++; $display("FAIL rst_text: got %h want 0", text_o); end
    rst = 1'b1;
  endtask

  task automatic test_single;
    logic [127:0] k;
    k = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    drive(1'b1, k, 1'b0, 1'b0);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", valid_o); end
    checks++; if (text_o !== k) begin errors++; $display("FAIL single_text: got %h want %h", text_o, k); end
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count_o); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 128'h0, 1'b0, 1'b0);
      checks++; if (text_o !== k) begin errors++; $display("FAIL single_hold: got %h want %h", text_o, k); end
    end
    drive(1'b0, 128'h0, 1'b1, 1'b0);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_after_pop: got %b want 0", valid_o); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL single_done_pulse: got %b want 1", done_o); end
    drive(1'b0, 128'h0, 1'b1, 1'b0);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL single_done_once: got %b want 0", done_o); end
    checks++; if (text_o !== 128'h0) begin errors++; $display("FAIL single_text_empty: got %h want 0", text_o); end
  endtask

  task automatic test_order_wrap;
    int start;
    start = n_popped;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 128'(i), (i % 2 == 0) || (i > 6), 1'b0);
    end
    drain(20);
    checks++; if (n_popped - start != 10) begin errors++; $display("FAIL order_pop_count: got %0d want 10", n_popped - start); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL order_count_end: got %0d want 0", count_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL order_ovf: got %b want 0", overflow_o); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 4; i++) drive(1'b1, 128'hA0 + 128'(i), 1'b0, 1'b0);
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full_o); end
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fill_ovf_pre: got %b want 0", overflow_o); end
    drive(1'b1, 128'hEE, 1'b0, 1'b0);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL fill_ovf_set: got %b want 1", overflow_o); end
    checks++; if (text_o !== 128'hA1) begin errors++; $display("FAIL fill_head: got %h want a1", text_o); end
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fill_count_drop: got %0d want 4", count_o); end
    drain(10);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL fill_drained: got %b want 0", valid_o); end
  endtask

  task automatic test_ovf_clear;
    drive(1'b0, 128'h0, 1'b0, 1'b1);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b want 0", overflow_o); end
    for (int i = 1; i <= 4; i++) drive(1'b1, 128'hB0 + 128'(i), 1'b0, 1'b0);
    drive(1'b1, 128'hEE, 1'b0, 1'b1);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL clr_vs_drop: got %b want 1", overflow_o); end
    drive(1'b0, 128'h0, 1'b0, 1'b1);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL clr_again: got %b want 0", overflow_o); end
  endtask

  // Entered with the FIFO full (B1..B4) and overflow clear.
  task automatic test_full_push_pop;
    drive(1'b1, 128'h55, 1'b1, 1'b0);
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fpp_count: got %0d want 4", count_o); end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b want 1", full_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b want 0", overflow_o); end
    checks++; if (text_o !== 128'hB2) begin errors++; $display("FAIL fpp_head: got %h want b2", text_o); end
    drain(10);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fpp_queue_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream;
    for (int i = 1; i <= 4; i++) drive(1'b1, 128'hC0 + 128'(i), 1'b0, 1'b0);
    drive(1'b1, 128'hEE, 1'b0, 1'b0);
    drive(1'b0, 128'h0, 1'b1, 1'b0);
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL mid_pre_count: got %0d want 3", count_o); end
    rst = 1'b0; ready_i = 1'b1; done_i = 1'b1; text_in = 128'hDEAD;
    exp_q.delete(); m_count = 0; m_ovf = 1'b0; m_last_pop = 1'b0;
    #2;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", count_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", valid_o); end
    checks++; if (text_o !== 128'h0) begin errors++; $display("FAIL mid_text: got %h want 0", text_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b want 0", overflow_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", done_o); end
    @(posedge clk);
    #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mid_done_held: got %b want 0", done_o); end
    done_i = 1'b0; ready_i = 1'b0; text_in = '0;
    rst = 1'b1;
    drive(1'b1, 128'hD1, 1'b0, 1'b0);
    checks++; if (text_o !== 128'hD1) begin errors++; $display("FAIL mid_after_text: got %h want d1", text_o); end
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL mid_after_count: got %0d want 1", count_o); end
    drain(10);
  endtask

  task automatic test_random;
    for (int i = 0; i < 150; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      checks++; if (count_o !== CW'(m_count)) begin errors++; $display("FAIL rnd_count: got %0d want %0d", count_o, m_count); end
      checks++; if (full_o !== (m_count == DEPTH)) begin errors++; $display("FAIL rnd_full: got %b want %b", full_o, (m_count == DEPTH)); end
      checks++; if (overflow_o !== m_ovf) begin errors++; $display("FAIL rnd_ovf: got %b want %b", overflow_o, m_ovf); end
    end
    drain(10);
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rnd_drained: got %0d want 0", count_o); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_order_wrap();
    test_fill();
    test_ovf_clear();
    test_full_push_pop();
    test_reset_midstream();
    test_random();
    repeat (2) drive(1'b0, 128'h0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
